// File: rtl/ser_bus_master.sv
// Byte-protocol bus initiator. A serial byte stream carries read (0x52) and
// write (0x57) commands with MSB-first address/data fields. The block issues
// a single bus request per command, waits for the matching acknowledge or a
// timeout, then streams the response bytes back to the serial transmitter.
module ser_bus_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_l_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic        bus_rd_req,
  output logic        bus_wr_req,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rd_ack,
  input  logic        bus_wr_ack,
  output logic        cmd_err
);

  localparam logic [7:0]  OP_READ   = 8'h52;
  localparam logic [7:0]  OP_WRITE  = 8'h57;
  localparam logic [7:0]  RSP_READ  = 8'h72;
  localparam logic [7:0]  RSP_WRITE = 8'h77;
  localparam logic [7:0]  RSP_TOUT  = 8'h54;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic        is_write;
  logic [15:0] wait_cnt;
  logic [31:0] rsp_shift;
  logic [2:0]  rsp_left;

  logic        is_opcode;
  logic        ack_hit;
  logic        timeout_hit;
  logic        tx_fire;
  logic        drop_byte;

  // Decode of the events that steer both the state machine and the datapath
  always_comb begin
    is_opcode   = (rx_data == OP_READ) || (rx_data == OP_WRITE);
    ack_hit     = (state == WAIT) && (is_write ? bus_wr_ack : bus_rd_ack);
    timeout_hit = (state == WAIT) && (wait_cnt == WAIT_LAST);
    tx_fire     = tx_valid && tx_ready;
    drop_byte   = rx_valid &&
                  (((state == IDLE) && !is_opcode) ||
                   (state == REQ) || (state == WAIT) || (state == RESP));
  end

  // State register
  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) state <= IDLE;
    else             state <= state_next;
  end

  // Next-state logic and the one-cycle bus request strobes
  always_comb begin
    state_next = state;
    bus_rd_req = 1'b0;
    bus_wr_req = 1'b0;
    case (state)
      IDLE: if (rx_valid && is_opcode) state_next = ADDR;
      ADDR: if (rx_valid && (byte_cnt == 2'd3)) state_next = is_write ? DATA : REQ;
      DATA: if (rx_valid && (byte_cnt == 2'd3)) state_next = REQ;
      REQ: begin
        bus_rd_req = !is_write;
        bus_wr_req = is_write;
        state_next = WAIT;
      end
      WAIT: if (ack_hit || timeout_hit) state_next = RESP;
      RESP: if (tx_fire && (rsp_left == 3'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command capture, timeout counting and response byte sequencing
  always_ff @(posedge clk or negedge reset_l_in) begin
    if (!reset_l_in) begin
      byte_cnt  <= 2'd0;
      is_write  <= 1'b0;
      wait_cnt  <= 16'd0;
      rsp_shift <= 32'd0;
      rsp_left  <= 3'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'h0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      bus_be  <= 4'hF;
      cmd_err <= drop_byte;
      case (state)
        IDLE: begin
          byte_cnt <= 2'd0;
          if (rx_valid && is_opcode) is_write <= (rx_data == OP_WRITE);
        end
        ADDR: begin
          if (rx_valid) begin
            bus_addr <= {bus_addr[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            bus_wdata <= {bus_wdata[23:0], rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        REQ: wait_cnt <= 16'd0;
        WAIT: begin
          if (ack_hit) begin
            tx_valid  <= 1'b1;
            tx_data   <= is_write ? RSP_WRITE : RSP_READ;
            rsp_shift <= bus_rdata;
            rsp_left  <= is_write ? 3'd0 : 3'd4;
          end else if (timeout_hit) begin
            tx_valid <= 1'b1;
            tx_data  <= RSP_TOUT;
            rsp_left <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (rsp_left != 3'd0) begin
              tx_data   <= rsp_shift[31:24];
              rsp_shift <= {rsp_shift[23:0], 8'd0};
              rsp_left  <= rsp_left - 3'd1;
            end else begin
              tx_valid <= 1'b0;
              tx_data  <= 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_bus_master.sv
// Scoreboard bench for ser_bus_master: expected bus requests and response
// bytes are queued as commands are sent and popped as the DUT emits them.
module tb_ser_bus_master;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        reset_l_in = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rd_req;
  logic        bus_wr_req;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_rd_ack = 1'b0;
  logic        bus_wr_ack = 1'b0;
  logic        cmd_err;

  ser_bus_master #(.TIMEOUT(TOUT)) dut (
    .clk(clk), .reset_l_in(reset_l_in),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rd_req(bus_rd_req), .bus_wr_req(bus_wr_req),
    .bus_rdata(bus_rdata), .bus_rd_ack(bus_rd_ack), .bus_wr_ack(bus_wr_ack),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [7:0]  exp_tx[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_seen = 0, req_total = 0;
  int          tx_seen = 0, tx_total = 0;
  int          err_seen = 0, err_total = 0;
  int          req_cyc = -1, tx_start = -1, ack_cyc = 0;
  logic [31:0] last_req_addr = 32'd0;
  logic [31:0] model_wdata = 32'd0;
  logic        rand_ready = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  data_prev = 8'd0;
  logic        valid_prev = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: score bus requests, response bytes, stall stability, cmd_err pulses
  always @(negedge clk) begin
    if (bus_rd_req || bus_wr_req) begin
      req_seen++;
      req_cyc = cyc;
      last_req_addr = bus_addr;
      if (exp_req.size() > 0) begin
        req_t e;
        e = exp_req.pop_front();
        checkOutput("req_kind", {31'd0, bus_wr_req}, {31'd0, e.wr});
        checkOutput("req_addr", bus_addr, e.addr);
        checkOutput("req_wdata", bus_wdata, e.wdata);
        checkOutput("req_be", {28'd0, bus_be}, 32'hF);
      end
    end
    if (stall_prev) begin
      checkOutput("hold_valid", {31'd0, tx_valid}, 32'd1);
      checkOutput("hold_data", {24'd0, tx_data}, {24'd0, data_prev});
    end
    if (tx_valid && !valid_prev) begin
      tx_start = cyc;
      checkOutput("addr_hold", bus_addr, last_req_addr);
    end
    if (tx_valid && tx_ready) begin
      tx_seen++;
      if (exp_tx.size() > 0) checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    end
    if (cmd_err) err_seen++;
    stall_prev = tx_valid && !tx_ready;
    data_prev  = tx_data;
    valid_prev = tx_valid;
  end

  // Random transmitter backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic sendRead(input logic [31:0] addr, input logic [31:0] rdata, input logic timeout);
    req_t r;
    r.wr = 1'b0; r.addr = addr; r.wdata = model_wdata;
    exp_req.push_back(r);
    req_total++;
    if (timeout) begin
      exp_tx.push_back(8'h54); tx_total++;
    end else begin
      exp_tx.push_back(8'h72);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[i*8 +: 8]);
      tx_total += 5;
    end
    applyStimulus(8'h52);
    for (int i = 3; i >= 0; i--) applyStimulus(addr[i*8 +: 8]);
  endtask

  task automatic waitReq();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus_rd_req || bus_wr_req) found = 1'b1;
    end
    checkOutput("req_found", {31'd0, found}, 32'd1);
    step();
  endtask

  task automatic pulseRdAck(input logic [31:0] rdata);
    bus_rd_ack = 1'b1;
    bus_rdata  = rdata;
    ack_cyc    = cyc;
    step();
    bus_rd_ack = 1'b0;
  endtask

  task automatic drainTx(input int bound);
    for (int i = 0; i < bound && exp_tx.size() > 0; i++) step();
    checkOutput("drain", exp_tx.size(), 32'd0);
    idleCycles(2);
  endtask

  initial begin
    int wr_last;
    req_t r;

    // Reset values
    @(negedge clk);
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_rd_req", {31'd0, bus_rd_req}, 32'd0);
    checkOutput("rst_wr_req", {31'd0, bus_wr_req}, 32'd0);
    checkOutput("rst_addr", bus_addr, 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    checkOutput("rst_be", {28'd0, bus_be}, 32'd0);
    checkOutput("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    step();
    reset_l_in = 1'b1;
    idleCycles(2);

    // Illegal byte in IDLE
    applyStimulus(8'h41);
    err_total++;
    idleCycles(2);
    checkOutput("err_idle", err_seen, err_total);

    // Read with stray byte and wrong ack during WAIT, ack 3 cycles after req
    sendRead(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    waitReq();
    applyStimulus(8'h99);
    err_total++;
    bus_wr_ack = 1'b1;
    step();
    bus_wr_ack = 1'b0;
    pulseRdAck(32'hDEAD_BEEF);
    drainTx(40);
    checkOutput("rd_tx_latency", tx_start, ack_cyc + 1);
    checkOutput("err_wait", err_seen, err_total);

    // Write with an ack coincident with REQ that must be ignored
    r.wr = 1'b1; r.addr = 32'h0300_0000; r.wdata = 32'h0000_005A;
    exp_req.push_back(r);
    req_total++;
    exp_tx.push_back(8'h77); tx_total++;
    applyStimulus(8'h57);
    applyStimulus(8'h03);
    repeat (6) applyStimulus(8'h00);
    applyStimulus(8'h5A);
    wr_last = cyc;
    model_wdata = 32'h0000_005A;
    bus_wr_ack = 1'b1;
    step();
    bus_wr_ack = 1'b0;
    idleCycles(2);
    bus_wr_ack = 1'b1;
    ack_cyc = cyc;
    step();
    bus_wr_ack = 1'b0;
    drainTx(40);
    checkOutput("wr_req_cycle", req_cyc, wr_last);
    checkOutput("wr_tx_latency", tx_start, ack_cyc + 1);

    // Timeout, then a late ack that must be ignored
    sendRead(32'h1122_3344, 32'd0, 1'b1);
    waitReq();
    drainTx(60);
    checkOutput("tout_latency", tx_start, req_cyc + TOUT + 1);
    bus_rd_ack = 1'b1;
    step();
    bus_rd_ack = 1'b0;
    idleCycles(4);

    // Read response under random backpressure
    rand_ready = 1'b1;
    sendRead(32'hCAFE_0000, 32'h0102_0304, 1'b0);
    waitReq();
    pulseRdAck(32'h0102_0304);
    drainTx(400);
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    idleCycles(2);

    // Reset during WAIT, late ack must not produce output
    sendRead(32'h0000_0044, 32'd0, 1'b0);
    void'(exp_tx.pop_back()); void'(exp_tx.pop_back()); void'(exp_tx.pop_back());
    void'(exp_tx.pop_back()); void'(exp_tx.pop_back());
    tx_total -= 5;
    waitReq();
    step();
    reset_l_in = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_addr", bus_addr, 32'd0);
    checkOutput("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    step();
    reset_l_in = 1'b1;
    model_wdata = 32'd0;
    step();
    pulseRdAck(32'hBAD0_BAD0);
    idleCycles(20);

    // Normal read after reset
    sendRead(32'h0000_0020, 32'h1234_5678, 1'b0);
    waitReq();
    step();
    pulseRdAck(32'h1234_5678);
    drainTx(40);
    checkOutput("post_rst_latency", tx_start, ack_cyc + 1);

    idleCycles(5);
    checkOutput("tx_count", tx_seen, tx_total);
    checkOutput("req_count", req_seen, req_total);
    checkOutput("err_count", err_seen, err_total);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
